keypad_entry: RTL

//   Consumer side of the keypad priority encoder: samples the encoder's digit code and
//   its no-key flag, debounces presses/releases, and accepts exactly one digit per press.

---
 rtl/keypad_entry_if.sv | 13 +
 rtl/keypad_entry.sv | 90 +++++++++
 2 files changed

// File: rtl/keypad_entry_if.sv
// keypad_entry_if: encoder/control inputs and BCD entry outputs of the keypad entry block.
interface keypad_entry_if;
   logic        enable;
   logic        clear;
   logic [3:0]  D;
   logic        no_key;
   logic [15:0] time_bcd;
   logic        key_pulse;
   logic [3:0]  key_digit;
   logic        nonzero;
   modport master (output enable, clear, D, no_key, input time_bcd, key_pulse, key_digit, nonzero);
   modport slave  (input enable, clear, D, no_key, output time_bcd, key_pulse, key_digit, nonzero);
endinterface

// File: rtl/keypad_entry.sv
// keypad_entry: debounces encoder presses/releases and shifts one BCD digit per press into MM:SS.
module keypad_entry #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input logic           clk,
   input logic           reset,
   keypad_entry_if.slave kp
);
   typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
   localparam logic [15:0] last_cnt = 16'(DEBOUNCE_CYCLES - 1);
   localparam bit single = (DEBOUNCE_CYCLES == 1);
   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  cand_q, cand_d;
   logic [15:0] time_q, time_d;
   logic        pulse_q, pulse_d;
   logic [3:0]  digit_q, digit_d;
   logic        nonzero_q, nonzero_d;
   logic        acc;
   logic [3:0]  acc_digit;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         cand_q    <= '0;
         time_q    <= '0;
         pulse_q   <= 1'b0;
         digit_q   <= '0;
         nonzero_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cand_q    <= cand_d;
         time_q    <= time_d;
         pulse_q   <= pulse_d;
         digit_q   <= digit_d;
         nonzero_q <= nonzero_d;
      end
   end
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cand_d    = cand_q;
      acc       = 1'b0;
      acc_digit = cand_q;
      case (state_q)
         IDLE:
            if (!kp.no_key && kp.enable) begin
               cand_d    = kp.D;
               acc       = single;
               acc_digit = kp.D;
               state_d   = single ? HELD : PRESS_WAIT;
               cnt_d     = single ? 16'd0 : 16'd1;
            end
         PRESS_WAIT:
            if (kp.no_key || kp.D != cand_q || !kp.enable) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == last_cnt) begin
               state_d = HELD;
               cnt_d   = '0;
               acc     = 1'b1;
            end else
               cnt_d = cnt_q + 16'd1;
         HELD:
            if (kp.no_key) begin
               state_d = single ? IDLE : RELEASE_WAIT;
               cnt_d   = single ? 16'd0 : 16'd1;
            end
         default:
            if (!kp.no_key) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == last_cnt) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else
               cnt_d = cnt_q + 16'd1;
      endcase
      // clear beats a coincident accept: no shift and no strobe
      pulse_d   = acc && acc_digit <= 4'd9 && !kp.clear;
      time_d    = kp.clear ? 16'd0 : pulse_d ? {time_q[11:0], acc_digit} : time_q;
      digit_d   = pulse_d ? acc_digit : digit_q;
      nonzero_d = time_d != 16'd0;
   end
   assign kp.time_bcd  = time_q;
   assign kp.key_pulse = pulse_q;
   assign kp.key_digit = digit_q;
   assign kp.nonzero   = nonzero_q;
endmodule
